// File: rtl/seg7_scan.sv
// seg7_scan
// Time-multiplexed scanner for a common-anode seven-segment display bank.
// Walks through DIGITS hex digits, one slot of REFRESH_DIV cycles per digit.
// Each slot starts with DEAD_CYCLES cycles of all anodes off to suppress ghosting.
// A newly loaded word is held back until the end of the frame, so a frame never
// mixes nibbles from two different words.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - asynchronous active-high reset
//   value      - hex word to display, nibble i drives digit i (digit 0 = LSN)
//   load       - capture value on this edge
//   lz_blank   - leading-zero blanking enable
//   nibble     - hex digit of the active slot, to the segment decoder
//   an         - active-low anode selects, at most one bit low
//   frame_done - one-cycle pulse on the last cycle of the last digit
//   pending    - a loaded word is waiting for the frame boundary
module seg7_scan #(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  lz_blank,
  output logic [3:0]            nibble,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done,
  output logic                  pending
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]         cnt, cnt_nx;
  logic [IW-1:0]         idx, idx_nx;
  logic [4*DIGITS-1:0]   shadow, shadow_nx;
  logic [4*DIGITS-1:0]   pend_word, pend_word_nx;
  logic                  pend_flag, pend_flag_nx;

  logic                  slot_end;
  logic                  boundary;
  logic [DIGITS-1:0]     zero_above;
  logic                  zero_run;
  logic [3:0]            nib_sel;
  logic                  sel_zero;
  logic                  blank;
  logic                  lit;
  logic [3:0]            nibble_nx;
  logic [DIGITS-1:0]     an_nx;
  logic                  frame_done_nx;

  // Next-state logic for the scan position and the word buffers.
  // A load coinciding with the frame boundary goes straight to the shadow.
  always_comb begin
    slot_end     = (cnt == CNT_LAST);
    boundary     = slot_end && (idx == IDX_LAST);
    cnt_nx       = slot_end ? '0 : cnt + CW'(1);
    idx_nx       = idx;
    if (slot_end) begin
      idx_nx = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end
    pend_word_nx = load ? value : pend_word;
    pend_flag_nx = pend_flag;
    shadow_nx    = shadow;
    if (boundary) begin
      pend_flag_nx = 1'b0;
      if (load) begin
        shadow_nx = value;
      end else if (pend_flag) begin
        shadow_nx = pend_word;
      end
    end else if (load) begin
      pend_flag_nx = 1'b1;
    end
  end

  // Output pre-computation from the next-state values, so the registered
  // outputs change on the same edge as the state they describe.
  // zero_above[i] is set when nibbles i..DIGITS-1 of the next shadow are zero.
  always_comb begin
    zero_run = 1'b1;
    zero_above = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (shadow_nx[4*i +: 4] == 4'h0);
      zero_above[i] = zero_run;
    end

    nib_sel  = 4'h0;
    sel_zero = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_nx == IW'(i)) begin
        nib_sel  = shadow_nx[4*i +: 4];
        sel_zero = zero_above[i];
      end
    end

    blank = lz_blank && (idx_nx != '0) && sel_zero;
    lit   = !blank && ((DEAD_CYCLES == 0) || (int'(cnt_nx) >= DEAD_CYCLES));

    an_nx = '1;
    if (lit) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (idx_nx == IW'(i)) begin
          an_nx[i] = 1'b0;
        end
      end
    end

    nibble_nx     = blank ? 4'h0 : nib_sel;
    frame_done_nx = (cnt_nx == CNT_LAST) && (idx_nx == IDX_LAST);
  end

  // Scan position and word buffers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      shadow    <= '0;
      pend_word <= '0;
      pend_flag <= 1'b0;
    end else begin
      cnt       <= cnt_nx;
      idx       <= idx_nx;
      shadow    <= shadow_nx;
      pend_word <= pend_word_nx;
      pend_flag <= pend_flag_nx;
    end
  end

  // Registered outputs, glitch-free toward the display pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an         <= '1;
      nibble     <= 4'h0;
      frame_done <= 1'b0;
      pending    <= 1'b0;
    end else begin
      an         <= an_nx;
      nibble     <= nibble_nx;
      frame_done <= frame_done_nx;
      pending    <= pend_flag_nx;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan
// Directed bench for seg7_scan. u0 runs DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1;
// u1 runs the single-digit, zero-dead-time corner with REFRESH_DIV=4.
// The bench tracks the scan position itself and is told by hand, step by step,
// which word is on display, which digits are lit and whether a load is pending.
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic        lz;
  logic [3:0]  nibble;
  logic [3:0]  an;
  logic        frame_done;
  logic        pending;

  logic        rst1;
  logic [3:0]  value1;
  logic        load1;
  logic        lz1;
  logic [3:0]  nibble1;
  logic [0:0]  an1;
  logic        frame_done1;
  logic        pending1;

  int checks = 0;
  int errors = 0;
  int pos = 0;
  string phase = "reset";

  seg7_scan #(.DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(1)) u0 (
    .clk(clk), .rst(rst), .value(value), .load(load), .lz_blank(lz),
    .nibble(nibble), .an(an), .frame_done(frame_done), .pending(pending)
  );

  seg7_scan #(.DIGITS(1), .REFRESH_DIV(4), .DEAD_CYCLES(0)) u1 (
    .clk(clk), .rst(rst1), .value(value1), .load(load1), .lz_blank(lz1),
    .nibble(nibble1), .an(an1), .frame_done(frame_done1), .pending(pending1)
  );

  always #5 clk = ~clk;

  // Compares one set of observed outputs against expected values.
  task automatic checkOutput(input string tag,
                             input logic [3:0] got_an,   input logic [3:0] exp_an,
                             input logic [3:0] got_nib,  input logic [3:0] exp_nib,
                             input logic       got_fd,   input logic       exp_fd,
                             input logic       got_pend, input logic       exp_pend);
    checks++;
    assert (got_an === exp_an) else begin
      errors++;
      $error("[TB] FAIL %s/%s an: got %b expected %b", phase, tag, got_an, exp_an);
    end
    checks++;
    assert (got_nib === exp_nib) else begin
      errors++;
      $error("[TB] FAIL %s/%s nibble: got %h expected %h", phase, tag, got_nib, exp_nib);
    end
    checks++;
    assert (got_fd === exp_fd) else begin
      errors++;
      $error("[TB] FAIL %s/%s frame_done: got %b expected %b", phase, tag, got_fd, exp_fd);
    end
    checks++;
    assert (got_pend === exp_pend) else begin
      errors++;
      $error("[TB] FAIL %s/%s pending: got %b expected %b", phase, tag, got_pend, exp_pend);
    end
  endtask

  // Drives one edge into u0 and checks the outputs after it. word is the word
  // expected on display after the edge, litm marks digits that are not blanked.
  task automatic applyStimulus(input logic ld, input logic [15:0] val,
                               input logic [15:0] word, input logic [3:0] litm,
                               input logic exp_pend);
    int c;
    int d;
    logic [3:0] exp_an;
    logic [3:0] exp_nib;
    load  = ld;
    value = val;
    @(posedge clk);
    #1;
    load = 1'b0;
    pos  = (pos + 1) % 16;
    c    = pos % 4;
    d    = pos / 4;
    exp_an  = (c == 0 || !litm[d]) ? 4'hF : ~(4'b0001 << d);
    exp_nib = litm[d] ? word[4*d +: 4] : 4'h0;
    checkOutput($sformatf("pos%0d", pos), an, exp_an, nibble, exp_nib,
                frame_done, (pos == 15), pending, exp_pend);
  endtask

  task automatic runSteps(input int n, input logic [15:0] word,
                          input logic [3:0] litm, input logic exp_pend);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 16'h0000, word, litm, exp_pend);
    end
  endtask

  initial begin
    rst = 1'b1; value = 16'h0; load = 1'b0; lz = 1'b0;
    rst1 = 1'b1; value1 = 4'h0; load1 = 1'b0; lz1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst", an, 4'hF, nibble, 4'h0, frame_done, 1'b0, pending, 1'b0);

    // First frame shows 0000 while 0x1234 waits; frame 2 shows it.
    phase = "scan";
    rst = 1'b0;
    pos = 0;
    applyStimulus(1'b1, 16'h1234, 16'h0000, 4'hF, 1'b1);
    runSteps(14, 16'h0000, 4'hF, 1'b1);
    runSteps(5, 16'h1234, 4'hF, 1'b0);

    // Load 0xABCD during slot 1; the rest of the frame keeps 0x1234.
    phase = "midload";
    applyStimulus(1'b1, 16'hABCD, 16'h1234, 4'hF, 1'b1);
    runSteps(10, 16'h1234, 4'hF, 1'b1);
    runSteps(2, 16'hABCD, 4'hF, 1'b0);
    applyStimulus(1'b1, 16'h1234, 16'hABCD, 4'hF, 1'b1);
    runSteps(13, 16'hABCD, 4'hF, 1'b1);
    runSteps(16, 16'h1234, 4'hF, 1'b0);

    // Load exactly on the boundary edge: shows at once, pending never rises.
    phase = "bndload";
    applyStimulus(1'b1, 16'hBEEF, 16'hBEEF, 4'hF, 1'b0);
    runSteps(15, 16'hBEEF, 4'hF, 1'b0);

    // Leading-zero blanking of 0x0050, then 0x0000.
    phase = "lzblank";
    runSteps(1, 16'hBEEF, 4'hF, 1'b0);
    lz = 1'b1;
    applyStimulus(1'b1, 16'h0050, 16'hBEEF, 4'hF, 1'b1);
    runSteps(14, 16'hBEEF, 4'hF, 1'b1);
    runSteps(17, 16'h0050, 4'b0011, 1'b0);
    applyStimulus(1'b1, 16'h0000, 16'h0050, 4'b0011, 1'b1);
    runSteps(14, 16'h0050, 4'b0011, 1'b1);
    runSteps(16, 16'h0000, 4'b0001, 1'b0);

    // Reset in slot 2 with 0x1234 shown and 0x5678 pending.
    phase = "midrst";
    lz = 1'b0;
    runSteps(1, 16'h0000, 4'hF, 1'b0);
    applyStimulus(1'b1, 16'h1234, 16'h0000, 4'hF, 1'b1);
    runSteps(14, 16'h0000, 4'hF, 1'b1);
    runSteps(1, 16'h1234, 4'hF, 1'b0);
    applyStimulus(1'b1, 16'h5678, 16'h1234, 4'hF, 1'b1);
    runSteps(8, 16'h1234, 4'hF, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("async", an, 4'hF, nibble, 4'h0, frame_done, 1'b0, pending, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pos = 0;
    runSteps(17, 16'h0000, 4'hF, 1'b0);

    // Single digit, no dead time: anode always on, every slot a frame.
    phase = "corner";
    checkOutput("rst1", {3'b000, an1}, 4'h1, nibble1, 4'h0, frame_done1, 1'b0, pending1, 1'b0);
    rst1   = 1'b0;
    load1  = 1'b1;
    value1 = 4'h9;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      load1 = 1'b0;
      checkOutput($sformatf("k%0d", k), {3'b000, an1}, 4'h0, nibble1,
                  (k >= 4) ? 4'h9 : 4'h0, frame_done1, (k % 4 == 3),
                  pending1, (k < 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Time-multiplexed scanner for a common-anode seven-segment display bank. Holds a DIGITS-nibble hex word (e.g. PC or a register value from the core), steps through the digits at a programmable refresh rate, and each slot presents one 4-bit nibble to the downstream hex-to-segment decoder plus an active-low anode select. Word updates are deferred to frame boundaries so a digit is never torn mid-frame. Leading-zero blanking and inter-digit dead time (anti-ghosting) are included.

## Interface
- `DIGITS`, 8, number of digits scanned, legal range 1..8.
- `REFRESH_DIV`, 100000, clock cycles per digit slot, must be ≥ `DEAD_CYCLES`+1.
- `DEAD_CYCLES`, 2, cycles at the start of each slot with all anodes off, legal range 0..`REFRESH_DIV`-1.

- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `value` input 4*DIGITS: hex word; nibble i drives digit i (digit 0 = least significant).
- `load` input 1: when high, capture `value` on this edge.
- `lz_blank` input 1: leading-zero blanking enable; sampled every cycle.
- `nibble` output 4: hex digit for the active slot, fed to the decoder's `val` input.
- `an` output DIGITS: anode selects, active-low, at most one bit low.
- `frame_done` output 1: one-cycle pulse on the last cycle of digit DIGITS-1.
- `pending` output 1: a loaded word is waiting for the frame boundary.

## Operation
- State: prescaler `cnt` (0..REFRESH_DIV-1), digit index `idx` (0..DIGITS-1), `pend_word`, `pend_flag`, and `shadow` (the displayed word).
- `cnt` increments every cycle. At `cnt`=REFRESH_DIV-1 it wraps to 0 and `idx` advances; `idx` wraps from DIGITS-1 to 0.
- The frame boundary is the edge where `cnt`=REFRESH_DIV-1 and `idx`=DIGITS-1. `frame_done`=1 during exactly that cycle.
- Load handling:
  - `load`=1 writes `value` into `pend_word` and sets `pend_flag`.
  - On the frame-boundary edge, `shadow` takes the pending word and `pend_flag` clears.
  - If `load` and the boundary coincide, `shadow` takes `value` directly and `pend_flag` stays 0.
  - Repeated loads within a frame: the last one wins.
- Digit i is blank when all of the following hold: `lz_blank`=1, i≠0, and shadow nibbles i..DIGITS-1 are all zero. Digit 0 is never blanked, so 0 displays as a single "0".
- `an[idx]`=0 only when `cnt` ≥ DEAD_CYCLES and digit `idx` is not blank. Every other `an` bit is 1.
- `nibble` = shadow nibble `idx` whenever the slot is not blank. For a blank slot, `nibble`=0; `an` keeps the digit dark regardless.
- `an`, `nibble`, `frame_done` and `pending` are registered (glitch-free). Each is computed from the next-state `cnt`/`idx`/`shadow`/flag values, so it changes on the same edge as the state it reflects.

## Timing
- Reset values:
  - `cnt`=0, `idx`=0, `shadow`=0, `pend_word`=0, `pend_flag`=0.
  - `an`=all ones, `nibble`=0, `frame_done`=0, `pending`=0.
- The first post-reset slot is digit 0, with its dead time counted from the first clock edge.
- Slot length is REFRESH_DIV cycles; frame length is DIGITS*REFRESH_DIV cycles.
- `pending` rises on the edge after `load` and falls on the frame-boundary edge.
- Load-to-display latency: minimum 1 cycle (load at the boundary); maximum DIGITS*REFRESH_DIV cycles.
- `lz_blank` changes take effect on the next edge.
- Reset asserted mid-frame:
  - All outputs return to reset values immediately.
  - The pending word is discarded.
- DEAD_CYCLES=0: an anode is on for the whole slot.
- DIGITS=1: every slot is a frame boundary.

## Test plan
Unless stated, parameters are DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1.
- **Reset and scan:** release `rst`, load 0x1234 at the first edge. Required:
  - The first frame shows 0000, with `pending`=1.
  - From frame 2, `nibble` runs 4,3,2,1 across slots.
  - `an` = 1111 for 1 cycle, then 1110 for 3 cycles; likewise 1101, 1011, 0111 in turn.
  - `frame_done` pulses every 16 cycles.
- **Mid-frame load:** with 0x1234 displayed, load 0xABCD during slot 1. Required:
  - Slots 1–3 still show 3,2,1.
  - The next frame shows D,C,B,A.
  - `pending` is high from the load until the boundary.
- **Load on boundary:** with 0x1234 displayed, assert `load`=0xBEEF exactly while `frame_done`=1. Required:
  - The next slot 0 shows F.
  - `pending` never rises.
- **Leading-zero blanking:** load 0x0050 with `lz_blank`=1. Required:
  - Digits 2 and 3 keep `an` all ones.
  - Digits 0 and 1 show 0 and 5.
  - Load 0x0000: only digit 0 lights, showing 0.
- **Reset mid-operation:** assert `rst` for 1 cycle mid-slot 2 with 0x1234 displayed and 0x5678 pending. Required:
  - `an`=1111, `nibble`=0 and `pending`=0 immediately.
  - The following frame shows 0000.
- **Parameter corner:** DEAD_CYCLES=0, DIGITS=1. Required:
  - `an`=0 continuously after reset.
  - `frame_done` pulses every 4 cycles.
  - A load takes effect within 4 cycles.
